// File: rtl/seq_det_ctrl_pkg.sv
// Shared state encoding and default widths for the seq_det_ctrl word-level controller.
`ifndef SEQ_DET_CTRL_BW_DATA
`define SEQ_DET_CTRL_BW_DATA 32
`endif
`ifndef SEQ_DET_CTRL_BW_CNT
`define SEQ_DET_CTRL_BW_CNT 6
`endif

package seq_det_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEF_BW_DATA = `SEQ_DET_CTRL_BW_DATA;
    localparam int DEF_BW_CNT  = `SEQ_DET_CTRL_BW_CNT;

    // Index counter width for a shifter of the given length (at least one bit).
    function automatic int idx_width(input int bw);
        if (bw > 1) begin
            idx_width = $clog2(bw);
        end else begin
            idx_width = 1;
        end
    endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Bus-side and detector-side signals of seq_det_ctrl; o_hitmap exists only with SEQ_DET_CTRL_HITMAP_EN.
interface seq_det_ctrl_if
    import seq_det_ctrl_pkg::*;
#(
    parameter int BW_DATA = DEF_BW_DATA,
    parameter int BW_CNT  = DEF_BW_CNT
);

    logic [BW_DATA-1:0] i_data;
    logic               i_valid;
    logic               o_ready;
    logic               o_seq;
    logic               o_det_rst;
    logic               i_det;
    logic [BW_CNT-1:0]  o_cnt;
    logic               o_done;
`ifdef SEQ_DET_CTRL_HITMAP_EN
    logic [BW_DATA-1:0] o_hitmap;

    modport master (
        output i_data, i_valid, i_det,
        input  o_ready, o_seq, o_det_rst, o_cnt, o_done, o_hitmap
    );

    modport slave (
        input  i_data, i_valid, i_det,
        output o_ready, o_seq, o_det_rst, o_cnt, o_done, o_hitmap
    );
`else
    modport master (
        output i_data, i_valid, i_det,
        input  o_ready, o_seq, o_det_rst, o_cnt, o_done
    );

    modport slave (
        input  i_data, i_valid, i_det,
        output o_ready, o_seq, o_det_rst, o_cnt, o_done
    );
`endif

endinterface

// File: rtl/seq_det_ctrl_piso.sv
// Parallel-load, MSB-first shifter with a bit-index counter and a last-bit flag.
module seq_det_ctrl_piso
    import seq_det_ctrl_pkg::*;
#(
    parameter int BW_DATA = DEF_BW_DATA,
    localparam int IDX_W  = idx_width(BW_DATA)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [BW_DATA-1:0] data,
    output logic               msb,
    output logic [IDX_W-1:0]   idx,
    output logic               last
);

    logic [BW_DATA-1:0] shreg_r;
    logic [IDX_W-1:0]   idx_r;

    // Shift register and bit index: load restarts the index at the first bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r <= '0;
            idx_r   <= '0;
        end else if (load) begin
            shreg_r <= data;
            idx_r   <= '0;
        end else if (shift) begin
            shreg_r <= shreg_r << 1;
            idx_r   <= idx_r + IDX_W'(1);
        end else begin
            shreg_r <= shreg_r;
            idx_r   <= idx_r;
        end
    end

    assign msb  = shreg_r[BW_DATA-1];
    assign idx  = idx_r;
    assign last = (idx_r == IDX_W'(BW_DATA - 1));

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-level controller for a bit-serial Moore detector: load, clear, shift MSB-first, count hits.
// Optional per-bit hit bitmap output enabled with SEQ_DET_CTRL_HITMAP_EN.
module seq_det_ctrl
    import seq_det_ctrl_pkg::*;
#(
    parameter int BW_DATA = DEF_BW_DATA,
    parameter int BW_CNT  = DEF_BW_CNT
) (
    input  logic           i_clk,
    input  logic           i_rst,
    seq_det_ctrl_if.slave  bus
);

    localparam int IDX_W = idx_width(BW_DATA);

    state_t             state_r;
    state_t             state_s;
    logic [BW_CNT-1:0]  acc_r;
    logic [BW_CNT-1:0]  acc_s;
    logic [BW_CNT-1:0]  cnt_r;
    logic               ready_r;
    logic               done_r;
    logic               load_s;
    logic               shift_s;
    logic               sample_s;
    logic               msb_s;
    logic               last_s;
    logic [IDX_W-1:0]   idx_s;
`ifdef SEQ_DET_CTRL_HITMAP_EN
    logic [BW_DATA-1:0] hmap_acc_r;
    logic [BW_DATA-1:0] hmap_acc_s;
    logic [BW_DATA-1:0] hmap_r;
`endif

    function automatic logic [BW_CNT-1:0] sat_inc(input logic [BW_CNT-1:0] v);
        if (v == {BW_CNT{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + BW_CNT'(1);
        end
    endfunction

    seq_det_ctrl_piso #(
        .BW_DATA (BW_DATA)
    ) u_piso (
        .clk   (i_clk),
        .rst   (i_rst),
        .load  (load_s),
        .shift (shift_s),
        .data  (bus.i_data),
        .msb   (msb_s),
        .idx   (idx_s),
        .last  (last_s)
    );

    // Next state and per-cycle strobes; the detector lags by one bit, so the first SHIFT sample is skipped.
    always_comb begin
        state_s  = state_r;
        load_s   = 1'b0;
        shift_s  = 1'b0;
        sample_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.i_valid && ready_r) begin
                    load_s  = 1'b1;
                    state_s = CLR;
                end else begin
                    state_s = IDLE;
                end
            end
            CLR: begin
                state_s = SHIFT;
            end
            SHIFT: begin
                shift_s  = 1'b1;
                sample_s = (idx_s != '0);
                if (last_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = SHIFT;
                end
            end
            DRAIN: begin
                sample_s = 1'b1;
                state_s  = DONE;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Hit accumulator update, cleared when a new word is accepted.
    always_comb begin
        acc_s = acc_r;
        if (load_s) begin
            acc_s = '0;
        end else if (sample_s && bus.i_det) begin
            acc_s = sat_inc(acc_r);
        end else begin
            acc_s = acc_r;
        end
    end

    // State, accumulator and registered handshake/result outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
            acc_r   <= '0;
            cnt_r   <= '0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            ready_r <= (state_s == IDLE);
            done_r  <= (state_s == DONE);
            if (state_r == DRAIN) begin
                cnt_r <= acc_s;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

`ifdef SEQ_DET_CTRL_HITMAP_EN
    // Hitmap accumulator: each sample enters at the LSB, so the first serial bit ends up at the MSB.
    always_comb begin
        hmap_acc_s = hmap_acc_r;
        if (load_s) begin
            hmap_acc_s = '0;
        end else if (sample_s) begin
            hmap_acc_s = {hmap_acc_r[BW_DATA-2:0], bus.i_det};
        end else begin
            hmap_acc_s = hmap_acc_r;
        end
    end

    // Hitmap registers, published together with o_cnt.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hmap_acc_r <= '0;
            hmap_r     <= '0;
        end else begin
            hmap_acc_r <= hmap_acc_s;
            if (state_r == DRAIN) begin
                hmap_r <= hmap_acc_s;
            end else begin
                hmap_r <= hmap_r;
            end
        end
    end

    assign bus.o_hitmap = hmap_r;
`endif

    assign bus.o_ready   = ready_r;
    assign bus.o_done    = done_r;
    assign bus.o_cnt     = cnt_r;
    assign bus.o_seq     = (state_r == SHIFT) ? msb_s : 1'b0;
    assign bus.o_det_rst = i_rst | (state_r == CLR);

endmodule
